// File: rtl/memory_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : memory_control
//  Purpose  : Memory-side responder for the per-core icache/dcache request
//             interface. Arbitrates instruction fetches and data loads/stores
//             from CPUS cores onto one single-ported RAM and returns a
//             one-cycle wait-low completion strobe (plus load data) to the
//             winning requester.
//  Ports    : CLK, nRST             clock, asynchronous active-low reset
//             iREN/iaddr            per-core instruction fetch request
//             iwait/iload           per-core fetch completion / data
//             dREN/dWEN/daddr/dstore per-core data request
//             dwait/dload           per-core data completion / load data
//             ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate  RAM side
//             Per-core vectors are flat: core c occupies [c*WORD_W +: WORD_W].
//  Revision : 1.0  initial release
// ============================================================================
module memory_control #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);

  localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;

  localparam logic [1:0] c_ram_access = 2'd2;
  localparam logic [1:0] c_ram_error  = 2'd3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t             r_state, w_state_nx;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_nx;
  logic [PTR_W-1:0]   r_own_core, w_own_core_nx;
  logic               r_own_data, w_own_data_nx;
  logic               r_own_write, w_own_write_nx;

  // Per-core unpacked views of the flat port vectors
  logic [WORD_W-1:0]  w_iaddr  [CPUS];
  logic [WORD_W-1:0]  w_daddr  [CPUS];
  logic [WORD_W-1:0]  w_dstore [CPUS];
  logic [WORD_W-1:0]  w_iload  [CPUS];
  logic [WORD_W-1:0]  w_dload  [CPUS];

  for (genvar c = 0; c < CPUS; c++) begin : g_core
    assign w_iaddr[c]                  = iaddr[c*WORD_W +: WORD_W];
    assign w_daddr[c]                  = daddr[c*WORD_W +: WORD_W];
    assign w_dstore[c]                 = dstore[c*WORD_W +: WORD_W];
    assign iload[c*WORD_W +: WORD_W]   = w_iload[c];
    assign dload[c*WORD_W +: WORD_W]   = w_dload[c];
  end

  // --------------------------------------------------------------------------
  // Round-robin pick within each class. Every core's distance from rr_ptr is
  // computed modulo CPUS; the closest requesting core wins its class.
  // --------------------------------------------------------------------------
  logic               w_d_found, w_i_found, w_d_write;
  logic [PTR_W-1:0]   w_d_core, w_i_core;
  int                 w_d_best, w_i_best, w_dist;

  always_comb begin
    w_d_found = 1'b0;
    w_d_core  = '0;
    w_d_write = 1'b0;
    w_d_best  = CPUS;
    w_i_found = 1'b0;
    w_i_core  = '0;
    w_i_best  = CPUS;
    w_dist    = 0;
    for (int c = 0; c < CPUS; c++) begin
      w_dist = c - int'(r_rr_ptr);
      if (w_dist < 0) w_dist = w_dist + CPUS;
      if ((dREN[c] || dWEN[c]) && (w_dist < w_d_best)) begin
        w_d_found = 1'b1;
        w_d_best  = w_dist;
        w_d_core  = PTR_W'(c);
        // dWEN with dREN together is serviced as a write
        w_d_write = dWEN[c];
      end
      if (iREN[c] && (w_dist < w_i_best)) begin
        w_i_found = 1'b1;
        w_i_best  = w_dist;
        w_i_core  = PTR_W'(c);
      end
    end
  end

  // Owner's live enable; dropping it during ACCESS aborts the transaction
  logic w_own_en;
  always_comb begin
    if (r_own_data) w_own_en = r_own_write ? dWEN[r_own_core] : dREN[r_own_core];
    else            w_own_en = iREN[r_own_core];
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_own_core  <= '0;
      r_own_data  <= 1'b0;
      r_own_write <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_rr_ptr    <= w_rr_nx;
      r_own_core  <= w_own_core_nx;
      r_own_data  <= w_own_data_nx;
      r_own_write <= w_own_write_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs. Completion is Mealy: the wait drops in the same
  // cycle the RAM reports ACCESS, so a zero-wait RAM gives 2-cycle latency.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx     = r_state;
    w_rr_nx        = r_rr_ptr;
    w_own_core_nx  = r_own_core;
    w_own_data_nx  = r_own_data;
    w_own_write_nx = r_own_write;
    iwait          = '1;
    dwait          = '1;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = '0;
    ramstore       = '0;
    for (int c = 0; c < CPUS; c++) begin
      w_iload[c] = '0;
      w_dload[c] = '0;
    end

    case (r_state)
      IDLE: begin
        if (w_d_found || w_i_found) begin
          w_state_nx     = ACCESS;
          w_own_data_nx  = w_d_found;
          w_own_core_nx  = w_d_found ? w_d_core : w_i_core;
          w_own_write_nx = w_d_found && w_d_write;
        end
      end

      ACCESS: begin
        if (!w_own_en) begin
          w_state_nx = IDLE;
        end else begin
          if (r_own_data) begin
            ramaddr = w_daddr[r_own_core];
            if (r_own_write) begin
              ramWEN   = 1'b1;
              ramstore = w_dstore[r_own_core];
            end else begin
              ramREN   = 1'b1;
            end
          end else begin
            ramREN  = 1'b1;
            ramaddr = w_iaddr[r_own_core];
          end

          if (ramstate == c_ram_access) begin
            if (r_own_data) begin
              dwait[r_own_core] = 1'b0;
              if (!r_own_write) w_dload[r_own_core] = ramload;
            end else begin
              iwait[r_own_core]   = 1'b0;
              w_iload[r_own_core] = ramload;
            end
            w_state_nx = IDLE;
            w_rr_nx    = (r_own_core == PTR_W'(CPUS - 1)) ? '0 : r_own_core + 1'b1;
          end else if (ramstate == c_ram_error) begin
            // Back to IDLE; the still-held request is re-arbitrated
            w_state_nx = IDLE;
          end
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire
